// File: rtl/count_pkg.sv
// count_pkg: shared state encoding and count-step constants for the count decoder
package count_pkg;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] D_HOLD = 3'd0;
  localparam logic [CNT_W-1:0] D_UP   = 3'd1;
  localparam logic [CNT_W-1:0] D_DOWN = 3'd7;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } cd_state_t;
endpackage

// File: rtl/count_delta.sv
// count_delta: classifies the modulo-8 change between two count samples
module count_delta
  import count_pkg::*;
(
  input  logic [CNT_W-1:0] i_prev,
  input  logic [CNT_W-1:0] i_cur,
  output logic             o_hold,
  output logic             o_up,
  output logic             o_down,
  output logic             o_skip,
  output logic             o_wrap_up,
  output logic             o_wrap_dn
);
  logic [CNT_W-1:0] w_d;
  // one-hot step class plus the 7->0 / 0->7 crossing flags
  always_comb begin
    w_d       = i_cur - i_prev;
    o_hold    = w_d == D_HOLD;
    o_up      = w_d == D_UP;
    o_down    = w_d == D_DOWN;
    o_skip    = !(o_hold || o_up || o_down);
    o_wrap_up = o_up && i_prev == 3'd7;
    o_wrap_dn = o_down && i_prev == 3'd0;
  end
endmodule

// File: rtl/count_decoder.sv
// count_decoder: follows a 3-bit count stream into a wide wrapping position with direction and fault status
module count_decoder
  import count_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             locked,
  output logic             fault
);
  cd_state_t        r_state, w_nxt_state;
  logic [CNT_W-1:0] r_prev, w_nxt_prev;
  logic [POS_W-1:0] r_pos, w_nxt_pos;
  logic             r_dir, w_nxt_dir;
  logic             r_step, w_nxt_step;
  logic             r_wrap, w_nxt_wrap;
  logic             r_fault, w_nxt_fault;
  logic             w_hold, w_up, w_down, w_skip, w_wrap_up, w_wrap_dn;
  logic             w_acc;

  count_delta u_delta (
    .i_prev    (r_prev),
    .i_cur     (cnt_in),
    .o_hold    (w_hold),
    .o_up      (w_up),
    .o_down    (w_down),
    .o_skip    (w_skip),
    .o_wrap_up (w_wrap_up),
    .o_wrap_dn (w_wrap_dn)
  );

  // a sample is acted on only when tracking, strobed, not cleared and actually moved
  assign w_acc = r_state == LOCKED && en && !clr && !w_hold;

  // next-state and next-output logic; clr overrides any step seen in the same cycle
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prev  = r_prev;
    w_nxt_pos   = r_pos;
    w_nxt_dir   = r_dir;
    w_nxt_step  = 1'b0;
    w_nxt_wrap  = 1'b0;
    w_nxt_fault = r_fault;
    case (r_state)
      UNLOCKED: begin
        w_nxt_pos = clr ? '0 : r_pos;
        if (en && !clr) begin
          w_nxt_prev  = cnt_in;
          w_nxt_state = LOCKED;
        end
      end
      LOCKED: begin
        w_nxt_prev = en ? cnt_in : r_prev;
        w_nxt_pos  = clr ? '0
                   : (w_acc && w_up) ? r_pos + POS_W'(1)
                   : (w_acc && w_down) ? r_pos - POS_W'(1)
                   : r_pos;
        w_nxt_dir  = (w_acc && (w_up || w_down)) ? w_up : r_dir;
        w_nxt_step = w_acc && (w_up || w_down);
        w_nxt_wrap = w_acc && (w_wrap_up || w_wrap_dn);
        if (w_acc && w_skip) begin
          w_nxt_fault = 1'b1;
          w_nxt_state = FAULT;
        end
      end
      default: begin
        if (clr) begin
          w_nxt_pos   = '0;
          w_nxt_fault = 1'b0;
          w_nxt_state = UNLOCKED;
        end
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= UNLOCKED;
    else     r_state <= w_nxt_state;
  end

  // sample history, position and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_prev  <= w_nxt_prev;
      r_pos   <= w_nxt_pos;
      r_dir   <= w_nxt_dir;
      r_step  <= w_nxt_step;
      r_wrap  <= w_nxt_wrap;
      r_fault <= w_nxt_fault;
    end
  end

  assign pos    = r_pos;
  assign dir    = r_dir;
  assign step   = r_step;
  assign wrap   = r_wrap;
  assign locked = r_state == LOCKED;
  assign fault  = r_fault;
endmodule

// File: tb/tb_count_decoder.sv
// tb_count_decoder: directed-vector bench for count_decoder
module tb_count_decoder;
  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [2:0] cnt_in;
  logic [7:0] pos;
  logic       dir, step, wrap, locked, fault;
  int         n_vec = 0;
  int         n_err = 0;

  count_decoder #(.POS_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .cnt_in (cnt_in),
    .pos    (pos),
    .dir    (dir),
    .step   (step),
    .wrap   (wrap),
    .locked (locked),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic e, input logic c, input logic [2:0] v);
    rst = r;
    en = e;
    clr = c;
    cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] ep, input logic ed, input logic es,
                     input logic ew, input logic el, input logic ef);
    n_vec++;
    assert ({pos, dir, step, wrap, locked, fault} === {ep, ed, es, ew, el, ef})
    else begin
      n_err++;
      $error("FAIL %s: got pos=%0d dir=%b step=%b wrap=%b locked=%b fault=%b, expected pos=%0d dir=%b step=%b wrap=%b locked=%b fault=%b",
             tag, pos, dir, step, wrap, locked, fault, ep, ed, es, ew, el, ef);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; cnt_in = 3'd0;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("reset", 8'd0, 0, 0, 0, 0, 0);
    // lock at 5 then count up across 7->0
    tick(0, 1, 0, 5); chk("lock5", 8'd0, 0, 0, 0, 1, 0);
    tick(0, 1, 0, 6); chk("up6", 8'd1, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 7); chk("up7", 8'd2, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 0); chk("up0_wrap", 8'd3, 1, 1, 1, 1, 0);
    tick(0, 0, 0, 0); chk("idle", 8'd3, 1, 0, 0, 1, 0);
    // clear with en re-references prev at 3, then count down across 0->7
    tick(0, 1, 1, 3); chk("clr_en3", 8'd0, 1, 0, 0, 1, 0);
    tick(0, 1, 0, 2); chk("dn2", 8'd255, 0, 1, 0, 1, 0);
    tick(0, 1, 0, 1); chk("dn1", 8'd254, 0, 1, 0, 1, 0);
    tick(0, 1, 0, 0); chk("dn0", 8'd253, 0, 1, 0, 1, 0);
    tick(0, 1, 0, 7); chk("dn7_wrap", 8'd252, 0, 1, 1, 1, 0);
    tick(0, 1, 0, 7); chk("hold7", 8'd252, 0, 0, 0, 1, 0);
    // reset mid-stream, relock at 2, one step up, then a skip
    tick(1, 1, 0, 6); chk("rst_mid", 8'd0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 2); chk("lock2", 8'd0, 0, 0, 0, 1, 0);
    tick(0, 1, 0, 3); chk("up3", 8'd1, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 6); chk("skip6", 8'd1, 1, 0, 0, 0, 1);
    tick(0, 1, 0, 7); chk("fault_frozen7", 8'd1, 1, 0, 0, 0, 1);
    tick(0, 1, 0, 0); chk("fault_frozen0", 8'd1, 1, 0, 0, 0, 1);
    tick(0, 0, 1, 0); chk("fault_clr", 8'd0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 2); chk("relock2", 8'd0, 1, 0, 0, 1, 0);
    // ten up steps from 2 ends at count 4 with pos 10
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 0, 3'((2 + i) % 8));
      chk("ramp", 8'(i), 1, 1, ((2 + i) % 8) == 0, 1, 0);
    end
    tick(0, 1, 1, 5); chk("clr_beats_step", 8'd0, 1, 0, 0, 1, 0);
    tick(0, 1, 0, 6); chk("after_clr_up", 8'd1, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 7); chk("up7b", 8'd2, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 0); chk("up0b", 8'd3, 1, 1, 1, 1, 0);
    // values seen without en are ignored
    tick(0, 0, 0, 4); chk("noen4", 8'd3, 1, 0, 0, 1, 0);
    tick(0, 0, 0, 1); chk("noen1", 8'd3, 1, 0, 0, 1, 0);
    tick(0, 1, 0, 1); chk("en1_up", 8'd4, 1, 1, 0, 1, 0);
    // climb to 37 then reset mid-count
    for (int i = 1; i <= 33; i++) begin
      tick(0, 1, 0, 3'((1 + i) % 8));
      chk("climb", 8'(4 + i), 1, 1, ((1 + i) % 8) == 0, 1, 0);
    end
    tick(0, 0, 0, 2); chk("at37", 8'd37, 1, 0, 0, 1, 0);
    tick(1, 1, 0, 3); chk("rst37", 8'd0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 3); chk("relock3", 8'd0, 0, 0, 0, 1, 0);
    tick(0, 1, 0, 4); chk("up4", 8'd1, 1, 1, 0, 1, 0);
    tick(0, 1, 0, 0); chk("skip_up", 8'd1, 1, 0, 0, 0, 1);
    tick(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
